// File: rtl/psg_write_queue.sv
// psg_write_queue: byte FIFO feeding an SN76489-style chip over the nCE/nWE/READY handshake.
module psg_write_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             err_clr,
  input  logic             READY,
  output logic [7:0]       D,
  output logic             nCE,
  output logic             nWE,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic [2:0]       latch_reg,
  output logic             overflow,
  output logic             timeout
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [TO_W-1:0]  r_to;
  logic             r_ok;
  logic             w_push, w_pop, w_to_hit;
  logic [CNT_W-1:0] w_cnt;
  assign w_push   = wr_en && !full;
  assign w_to_hit = r_to == TO_W'(TIMEOUT - 1);
  assign w_cnt    = count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign busy     = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop  = !empty;
        w_next = empty ? IDLE : SETUP;
      end
      SETUP:  w_next = STROBE;
      STROBE: w_next = (!READY || w_to_hit) ? RELEASE : STROBE;
      RELEASE: begin
        w_pop  = READY && !empty;
        w_next = !READY ? RELEASE : (empty ? IDLE : SETUP);
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wp] <= wr_data;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_to      <= '0;
      r_ok      <= 1'b0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      D         <= 8'h00;
      nCE       <= 1'b1;
      nWE       <= 1'b1;
      latch_reg <= 3'b000;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
        D    <= r_mem[r_rp];
      end
      count <= w_cnt;
      full  <= w_cnt == CNT_W'(DEPTH);
      empty <= w_cnt == '0;
      nCE   <= w_next != STROBE;
      nWE   <= w_next != STROBE;
      // counter is zero on STROBE entry and saturates once the limit is reached
      r_to  <= (r_state != STROBE) ? '0 : (r_to == TO_W'(TIMEOUT)) ? r_to : r_to + 1'b1;
      if (r_state == STROBE) r_ok <= !READY;
      if (r_state == RELEASE && READY && r_ok && D[7]) latch_reg <= D[6:4];
      overflow <= (wr_en && full) || (overflow && !err_clr);
      timeout  <= (r_state == STROBE && READY && w_to_hit) || (timeout && !err_clr);
    end
  end
endmodule

// File: tb/tb_psg_write_queue.sv
// tb_psg_write_queue: random and directed traffic against a transaction-level scoreboard.
module tb_psg_write_queue;
  localparam int DEPTH = 4, TIMEOUT = 16, CNT_W = $clog2(DEPTH + 1);
  logic CLK = 0, nRST = 0, wr_en = 0, err_clr = 0, READY;
  logic [7:0] wr_data = 0;
  logic [7:0] D;
  logic nCE, nWE, full, empty, busy, overflow, timeout;
  logic [CNT_W-1:0] count;
  logic [2:0] latch_reg;
  int n_chk = 0, n_err = 0;
  logic auto_rdy = 1, man_rdy = 1;

  psg_write_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .wr_en(wr_en), .wr_data(wr_data), .err_clr(err_clr),
    .READY(READY), .D(D), .nCE(nCE), .nWE(nWE), .full(full), .empty(empty),
    .count(count), .busy(busy), .latch_reg(latch_reg), .overflow(overflow), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // chip-side responder: drops READY a few cycles into a strobe, raises it after release
  initial begin
    int dly;
    READY = 1;
    dly = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (!auto_rdy) READY = man_rdy;
      else if (!nCE && READY) begin
        if (dly == 0) begin READY = 0; dly = $urandom_range(0, 3); end
        else dly--;
      end else if (nCE && !READY) begin
        if (dly == 0) begin READY = 1; dly = $urandom_range(0, 3); end
        else dly--;
      end
    end
  end

  // scoreboard: accepted bytes in order, occupancy, sticky flags, latched register
  logic [7:0] q[$];
  int cp, len;
  logic acc_p, att_n, clr_n, prev_nce, in_dlv, fell, rose, tmo;
  logic [7:0] dat_n, cur;
  logic [CNT_W-1:0] cnt_p;
  logic full_p, empty_p, ovf_m, to_m;
  logic [2:0] lat_m;

  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        q.delete();
        cp = 0; acc_p = 0; att_n = 0; clr_n = 0; dat_n = 0;
        cnt_p = 0; full_p = 0; empty_p = 1; prev_nce = 1;
        in_dlv = 0; len = 0; cur = 0; lat_m = 0; ovf_m = 0; to_m = 0;
      end else begin
        fell = prev_nce && !nCE;
        rose = !prev_nce && nCE;
        cp = cp + int'(acc_p) - int'(fell);
        check("count", cnt_p, cp);
        check("full", full_p, cp == DEPTH);
        check("empty", empty_p, cp == 0);
        acc_p = att_n && cp < DEPTH;
        if (acc_p) q.push_back(dat_n);
        check("nwe_eq_nce", nWE, nCE);
        tmo = rose && !in_dlv;
        if (rose) begin
          if (!in_dlv) check("timeout_len", len, TIMEOUT);
          else if (cur[7]) lat_m = cur[6:4];
        end
        ovf_m = (att_n && cp == DEPTH) || (ovf_m && !clr_n);
        to_m  = tmo || (to_m && !clr_n);
        check("overflow", overflow, ovf_m);
        check("timeout", timeout, to_m);
        if (fell) begin
          check("strobe_has_byte", q.size() != 0, 1);
          if (q.size() != 0) cur = q.pop_front();
          check("latch_reg", latch_reg, lat_m);
          len = 0;
          in_dlv = 0;
        end
        if (!nCE) begin
          len++;
          check("d_in_strobe", D, cur);
          if (!READY) in_dlv = 1;
        end
        prev_nce = nCE; cnt_p = count; full_p = full; empty_p = empty;
        att_n = wr_en; clr_n = err_clr; dat_n = wr_data;
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] b, input logic clr);
    @(posedge CLK);
    #1;
    wr_en = we; wr_data = b; err_clr = clr;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!busy && empty && nCE) break;
    end
    check("idle_reached", !busy && empty, 1);
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!nCE) break;
    end
    check("strobe_reached", !nCE, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic low_seen;
    repeat (2) @(negedge CLK);
    check("rst_D", D, 8'h00);
    check("rst_nCE", nCE, 1);
    check("rst_nWE", nWE, 1);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_latch", latch_reg, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    @(negedge CLK);
    #2 nRST = 1;
    // single write and its latency
    drive(1, 8'h9F, 0);
    drive(0, 8'h00, 0);
    @(negedge CLK);
    check("lat_edge_n", nCE, 1);
    @(negedge CLK);
    check("lat_edge_n1", nCE, 1);
    check("busy_setup", busy, 1);
    @(negedge CLK);
    check("lat_edge_n2", nCE, 0);
    check("single_D", D, 8'h9F);
    wait_idle();
    check("single_latch", latch_reg, 3'b001);
    check("single_busy", busy, 0);
    // burst of three
    drive(1, 8'h8F, 0);
    drive(1, 8'h3F, 0);
    drive(1, 8'h90, 0);
    drive(0, 8'h00, 0);
    wait_idle();
    check("burst_latch", latch_reg, 3'b001);
    // overflow with READY parked high
    auto_rdy = 0; man_rdy = 1;
    for (int i = 0; i < DEPTH + 2; i++) drive(1, 8'hA0 + 8'(i), 0);
    drive(0, 8'h00, 0);
    @(negedge CLK);
    check("ovf_count", count, DEPTH);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    auto_rdy = 1;
    wait_idle();
    check("ovf_latch", latch_reg, 3'b010);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    @(negedge CLK);
    check("ovf_cleared", overflow, 0);
    // handshake timeout, then the next byte completes normally
    auto_rdy = 0; man_rdy = 1;
    drive(1, 8'hC5, 0);
    drive(1, 8'h87, 0);
    drive(0, 8'h00, 0);
    for (int i = 0; i < 100; i++) begin
      if (timeout) break;
      @(negedge CLK);
    end
    check("to_set", timeout, 1);
    check("to_strobe_high", nCE, 1);
    check("to_latch_kept", latch_reg, 3'b010);
    auto_rdy = 1;
    wait_idle();
    check("to_next_latch", latch_reg, 3'b000);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    @(negedge CLK);
    check("to_cleared", timeout, 0);
    // push and pop on the same edge at count 1
    auto_rdy = 0; man_rdy = 1;
    drive(1, 8'h11, 0);
    drive(0, 8'h00, 0);
    wait_strobe();
    drive(1, 8'h22, 0);
    @(posedge CLK); #1 wr_en = 0; man_rdy = 0;
    @(posedge CLK); #1 wr_en = 1; wr_data = 8'h33; man_rdy = 1;
    @(posedge CLK); #1 wr_en = 0;
    @(negedge CLK);
    check("pushpop_count", count, 1);
    check("pushpop_D", D, 8'h22);
    auto_rdy = 1;
    wait_idle();
    // reset in the middle of a strobe
    auto_rdy = 0; man_rdy = 1;
    drive(1, 8'hB1, 0);
    drive(1, 8'hB2, 0);
    drive(0, 8'h00, 0);
    wait_strobe();
    #2 nRST = 0;
    #1;
    check("arst_nCE", nCE, 1);
    check("arst_nWE", nWE, 1);
    repeat (2) @(negedge CLK);
    #2 nRST = 1;
    @(negedge CLK);
    check("arst_count", count, 0);
    check("arst_D", D, 8'h00);
    check("arst_empty", empty, 1);
    low_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (!nCE) low_seen = 1;
    end
    check("arst_no_strobe", low_seen, 0);
    // randomized traffic with bursty pushes and occasional flag clears
    auto_rdy = 1;
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 99) < ((i % 100 < 40) ? 75 : 12), 8'($urandom), $urandom_range(0, 19) == 0);
    drive(0, 8'h00, 0);
    wait_idle();
    repeat (3) @(negedge CLK);
    check("final_latch", latch_reg, lat_m);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
